// File: rtl/coeff_sub_add_reg.sv
// One coefficient lane of the NTRU-HRSS multiplier: conditional invert of h,
// carry-select add with e (mod 2^W), and a registered result.

module Xor_N_bit #(
  parameter int W = 13
) (
  input  logic [W-1:0] h,
  input  logic         r,
  output logic [W-1:0] out_xor
);

  assign out_xor = h ^ {W{r}};

endmodule

// Ripple-carry low nibble; every upper block is precomputed for both carry-in
// values and selected by the true block carry. MSB carry-out is dropped (mod 2^W).
module carryselectadder #(
  parameter int W = 13
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         cin,
  output logic [W-1:0] out
);

  localparam int NB = (W + 3) / 4;

  logic [NB-1:0] blk_carry_s;

  assign blk_carry_s[0] = cin;

  for (genvar b = 0; b < NB; b++) begin : g_blk
    localparam int LO = 4 * b;
    localparam int BW = ((W - LO) < 4) ? (W - LO) : 4;
    localparam int CW = (b < NB - 1) ? BW + 1 : BW;

    if (b == 0) begin : g_ripple
      logic [BW:0] c_s;
      assign c_s[0] = cin;
      for (genvar i = 0; i < BW; i++) begin : g_fa
        assign out[LO+i] = in1[LO+i] ^ in2[LO+i] ^ c_s[i];
        if (i < BW - 1 || NB > 1) begin : g_c
          assign c_s[i+1] = (in1[LO+i] & in2[LO+i]) | (c_s[i] & (in1[LO+i] ^ in2[LO+i]));
        end else begin : g_nc
          assign c_s[i+1] = 1'b0;
        end
      end
      if (NB > 1) begin : g_co
        assign blk_carry_s[1] = c_s[BW];
      end
    end else begin : g_select
      logic [CW-1:0] sum0_s;
      logic [CW-1:0] sum1_s;
      assign sum0_s = CW'(in1[LO +: BW]) + CW'(in2[LO +: BW]);
      assign sum1_s = CW'(in1[LO +: BW]) + CW'(in2[LO +: BW]) + CW'(1);
      assign out[LO +: BW] = blk_carry_s[b] ? sum1_s[BW-1:0] : sum0_s[BW-1:0];
      if (b < NB - 1) begin : g_co
        assign blk_carry_s[b+1] = blk_carry_s[b] ? sum1_s[BW] : sum0_s[BW];
      end
    end
  end

endmodule

module Regfile #(
  parameter int W = 13
) (
  input  logic [W-1:0] in1,
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] out
);

  // Coefficient register; no enable, the parent gates clk to freeze it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= {W{1'b0}};
    end else begin
      out <= in1;
    end
  end

endmodule

module coeff_sub_add_reg #(
  parameter int W = 13
) (
  input  logic         lcl_clk,
  input  logic         rst,
  input  logic [W-1:0] e,
  input  logic [W-1:0] h,
  input  logic         neg,
  output logic [W-1:0] out_xor,
  output logic [W-1:0] sum,
  output logic [W-1:0] q
);

  Xor_N_bit #(.W(W)) u_xor (
    .h       (h),
    .r       (neg),
    .out_xor (out_xor)
  );

  // neg doubles as carry-in so inverted h plus one forms the two's complement.
  carryselectadder #(.W(W)) u_add (
    .in1 (e),
    .in2 (out_xor),
    .cin (neg),
    .out (sum)
  );

  Regfile #(.W(W)) u_reg (
    .in1 (sum),
    .clk (lcl_clk),
    .rst (rst),
    .out (q)
  );

endmodule

// File: tb/tb_coeff_sub_add_reg.sv
// Directed and random checks of coeff_sub_add_reg against a modular-arithmetic model.

module tb_coeff_sub_add_reg;

  localparam int W = 13;
  localparam int MASK = 32'h1FFF;

  logic         base_clk = 1'b0;
  logic         clk_en = 1'b1;
  logic         lcl_clk;
  logic         rst = 1'b1;
  logic [W-1:0] e = '0;
  logic [W-1:0] h = '0;
  logic         neg = 1'b0;
  logic [W-1:0] out_xor;
  logic [W-1:0] sum;
  logic [W-1:0] q;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] model_next;
  logic [W-1:0] model_q;

  always #5 base_clk = ~base_clk;
  assign lcl_clk = base_clk & clk_en;

  coeff_sub_add_reg #(.W(W)) dut (
    .lcl_clk (lcl_clk),
    .rst     (rst),
    .e       (e),
    .h       (h),
    .neg     (neg),
    .out_xor (out_xor),
    .sum     (sum),
    .q       (q)
  );

  // Model: subtraction or addition modulo 2^W.
  function automatic logic [W-1:0] ref_sum(input int a, input int b, input bit n);
    int t;
    t = n ? (a - b) : (a + b);
    return W'(t & MASK);
  endfunction

  function automatic logic [W-1:0] ref_xor(input int b, input bit n);
    return W'(n ? (MASK - b) : b);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs while the clock is low, then check the combinational outputs.
  task automatic drive(input bit r, input int ev, input int hv, input bit n, input bit en);
    @(negedge base_clk);
    clk_en = en;
    rst = r;
    e = W'(ev);
    h = W'(hv);
    neg = n;
    #1;
    check("out_xor", out_xor, ref_xor(hv, n));
    check("sum", sum, ref_sum(ev, hv, n));
    model_next = r ? W'(0) : ref_sum(ev, hv, n);
  endtask

  task automatic tick(input string tag);
    @(posedge base_clk);
    #1;
    if (clk_en) model_q = model_next;
    check(tag, q, model_q);
  endtask

  initial begin
    drive(1'b1, 32'h1FFF, 32'h0ABC, 1'b0, 1'b1);
    tick("q_reset");
    drive(1'b0, 5, 3, 1'b0, 1'b1);
    tick("q_add_after_reset");
    check("q_is_8", q, 13'd8);

    drive(1'b0, 10, 3, 1'b1, 1'b1);
    check("sub_xor", out_xor, 13'h1FFC);
    check("sub_sum", sum, 13'd7);
    tick("q_sub");

    drive(1'b0, 32'h1FFF, 1, 1'b0, 1'b1);
    check("wrap_add", sum, 13'h0000);
    tick("q_wrap_add");
    drive(1'b0, 0, 1, 1'b1, 1'b1);
    check("wrap_sub", sum, 13'h1FFF);
    tick("q_wrap_sub");

    drive(1'b0, 32'h000F, 1, 1'b0, 1'b1);
    check("csa_b4", sum, 13'h0010);
    drive(1'b0, 32'h00FF, 1, 1'b0, 1'b1);
    check("csa_b8", sum, 13'h0100);
    drive(1'b0, 32'h0FFF, 1, 1'b0, 1'b1);
    check("csa_b12", sum, 13'h1000);
    drive(1'b0, 32'h0FFF, 32'h1000, 1'b0, 1'b1);
    check("csa_top", sum, 13'h1FFF);
    tick("q_csa");

    // Reset asserted mid-stream wins over data.
    drive(1'b1, 32'h1234, 32'h0777, 1'b1, 1'b1);
    tick("q_reset_mid");
    drive(1'b0, 32'h0123, 32'h0045, 1'b0, 1'b1);
    tick("q_first_after_rst");

    // Gated clock: q must hold while inputs move.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, $urandom_range(0, MASK), $urandom_range(0, MASK), 1'($urandom_range(0, 1)), 1'b0);
      tick("q_hold");
    end
    drive(1'b0, 32'h0AAA, 32'h0555, 1'b0, 1'b1);
    tick("q_ungated");
    check("q_ungated_val", q, 13'h0FFF);

    for (int i = 0; i < 10000; i++) begin
      drive(1'b0, $urandom_range(0, MASK), $urandom_range(0, MASK), 1'($urandom_range(0, 1)), 1'b1);
      tick("q_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
